// File: rtl/cpu_pkg.sv
// Shared encodings for the decode stage: ALU codes, opcode/funct values,
// instruction-class tags and the decoded control word with its builders.
package cpu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;

   localparam logic [3:0] INS_TYPE_NOP   = 4'd0;
   localparam logic [3:0] INS_TYPE_RALU  = 4'd1;
   localparam logic [3:0] INS_TYPE_SHIFT = 4'd2;
   localparam logic [3:0] INS_TYPE_IALU  = 4'd3;
   localparam logic [3:0] INS_TYPE_LW    = 4'd4;
   localparam logic [3:0] INS_TYPE_SW    = 4'd5;
   localparam logic [3:0] INS_TYPE_BEQ   = 4'd6;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      IMM_ZERO = 2'd0,
      IMM_SEXT = 2'd1,
      IMM_ZEXT = 2'd2,
      IMM_BR   = 2'd3
   } imm_sel_t;

   typedef struct packed {
      logic       wreg;
      logic       m2reg;
      logic       wmem;
      logic       aluimm;
      logic       shift;
      logic       branch;
      logic       regrt;
      logic       use_rs;
      logic       use_rt;
      logic [3:0] aluc;
      logic [3:0] ins_type;
      imm_sel_t   imm_sel;
   } ctrl_t;

   function automatic ctrl_t ctrl_r_alu(input logic [3:0] op);
      ctrl_t c;
      c          = '0;
      c.wreg     = 1'b1;
      c.use_rs   = 1'b1;
      c.use_rt   = 1'b1;
      c.aluc     = op;
      c.ins_type = INS_TYPE_RALU;
      c.imm_sel  = IMM_SEXT;
      return c;
   endfunction

   // Shifts take rt as the shifted value; rs is a don't-care field.
   function automatic ctrl_t ctrl_r_shift(input logic [3:0] op);
      ctrl_t c;
      c          = '0;
      c.wreg     = 1'b1;
      c.shift    = 1'b1;
      c.use_rt   = 1'b1;
      c.aluc     = op;
      c.ins_type = INS_TYPE_SHIFT;
      c.imm_sel  = IMM_SEXT;
      return c;
   endfunction

   function automatic ctrl_t ctrl_i_alu(input logic [3:0] op, input logic zext);
      ctrl_t c;
      c          = '0;
      c.wreg     = 1'b1;
      c.aluimm   = 1'b1;
      c.regrt    = 1'b1;
      c.use_rs   = 1'b1;
      c.aluc     = op;
      c.ins_type = INS_TYPE_IALU;
      c.imm_sel  = zext ? IMM_ZEXT : IMM_SEXT;
      return c;
   endfunction

   function automatic ctrl_t ctrl_mem(input logic is_store);
      ctrl_t c;
      c          = '0;
      c.wreg     = ~is_store;
      c.m2reg    = ~is_store;
      c.wmem     = is_store;
      c.aluimm   = 1'b1;
      c.regrt    = 1'b1;
      c.use_rs   = 1'b1;
      c.use_rt   = is_store;
      c.aluc     = ALU_ADD;
      c.ins_type = is_store ? INS_TYPE_SW : INS_TYPE_LW;
      c.imm_sel  = IMM_SEXT;
      return c;
   endfunction

   function automatic ctrl_t ctrl_beq();
      ctrl_t c;
      c          = '0;
      c.branch   = 1'b1;
      c.regrt    = 1'b1;
      c.use_rs   = 1'b1;
      c.use_rt   = 1'b1;
      c.aluc     = ALU_SUB;
      c.ins_type = INS_TYPE_BEQ;
      c.imm_sel  = IMM_BR;
      return c;
   endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file, two combinational read ports and one write port.
// With WB_BYPASS_EN defined, a same-cycle write is forwarded to the reads.
module regfile
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] mem_q [32];
   logic [31:0] mem_d [32];

   always_comb begin
      mem_d = mem_q;
      if (we && (wa != 5'd0)) begin
         mem_d[wa] = wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   function automatic logic [31:0] read_port(input logic [4:0] ra);
      logic [31:0] v;
      v = '0;
      if (ra != 5'd0) begin
`ifdef WB_BYPASS_EN
         v = (we && (wa == ra)) ? wd : mem_q[ra];
`else
         v = mem_q[ra];
`endif
      end
      return v;
   endfunction

   always_comb begin
      rd1 = read_port(ra1);
      rd2 = read_port(ra2);
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, decoder and RAW stall unit.
// Build option WB_BYPASS_EN forwards the WB write into the reads and drops WB from the stall check.
module id_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc4,
   input  logic        id_flush,
   input  logic        ex_wreg,
   input  logic [4:0]  ex_destR,
   input  logic        mem_wreg,
   input  logic [4:0]  mem_destR,
   input  logic        wb_wreg,
   input  logic [4:0]  wb_destR,
   input  logic [31:0] wb_data,
   output logic        id_stall,
   output logic [31:0] id_inA,
   output logic [31:0] id_inB,
   output logic [31:0] id_imm,
   output logic [31:0] id_pc4,
   output logic        id_wreg,
   output logic        id_m2reg,
   output logic        id_wmem,
   output logic        id_aluimm,
   output logic        id_shift,
   output logic        id_branch,
   output logic        id_regrt,
   output logic [3:0]  id_aluc,
   output logic [4:0]  id_rt,
   output logic [4:0]  id_rd,
   output logic [3:0]  ID_ins_type,
   output logic [3:0]  ID_ins_number
);

   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;
   logic [3:0]  num_q, num_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;
   ctrl_t       dec;
   logic        hazard;
   logic        bubble;

   assign opcode = inst_q[31:26];
   assign rs     = inst_q[25:21];
   assign rt     = inst_q[20:16];
   assign rd     = inst_q[15:11];
   assign imm16  = inst_q[15:0];
   assign funct  = inst_q[5:0];

   regfile u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (rs),
      .ra2   (rt),
      .rd1   (id_inA),
      .rd2   (id_inB),
      .we    (wb_wreg),
      .wa    (wb_destR),
      .wd    (wb_data)
   );

   // Anything outside the supported subset, including the all-zero word, stays a NOP.
   always_comb begin
      dec = '0;
      case (opcode)
         OP_RTYPE: begin
            if (inst_q != NOP_WORD) begin
               case (funct)
                  FN_ADD:  dec = ctrl_r_alu(ALU_ADD);
                  FN_SUB:  dec = ctrl_r_alu(ALU_SUB);
                  FN_AND:  dec = ctrl_r_alu(ALU_AND);
                  FN_OR:   dec = ctrl_r_alu(ALU_OR);
                  FN_XOR:  dec = ctrl_r_alu(ALU_XOR);
                  FN_SLL:  dec = ctrl_r_shift(ALU_SLL);
                  FN_SRL:  dec = ctrl_r_shift(ALU_SRL);
                  FN_SRA:  dec = ctrl_r_shift(ALU_SRA);
                  default: dec = '0;
               endcase
            end
         end
         OP_ADDI: dec = ctrl_i_alu(ALU_ADD, 1'b0);
         OP_ANDI: dec = ctrl_i_alu(ALU_AND, 1'b1);
         OP_ORI:  dec = ctrl_i_alu(ALU_OR, 1'b1);
         OP_LW:   dec = ctrl_mem(1'b0);
         OP_SW:   dec = ctrl_mem(1'b1);
         OP_BEQ:  dec = ctrl_beq();
         default: dec = '0;
      endcase
   end

   always_comb begin
      id_imm = '0;
      case (dec.imm_sel)
         IMM_SEXT: id_imm = {{16{imm16[15]}}, imm16};
         IMM_ZEXT: id_imm = {16'h0000, imm16};
         IMM_BR:   id_imm = {{14{imm16[15]}}, imm16, 2'b00};
         default:  id_imm = '0;
      endcase
   end

   function automatic logic pending_write(input logic [4:0] r);
      logic hit;
      hit = (ex_wreg && (ex_destR == r)) || (mem_wreg && (mem_destR == r));
`ifndef WB_BYPASS_EN
      hit = hit || (wb_wreg && (wb_destR == r));
`endif
      return (r != 5'd0) && hit;
   endfunction

   always_comb begin
      hazard = (dec.use_rs && pending_write(rs)) || (dec.use_rt && pending_write(rt));
   end

   // A flush redirects fetch, so it masks the stall and bubbles the current slot.
   assign id_stall = hazard && !id_flush;
   assign bubble   = hazard || id_flush;

   assign id_pc4        = pc4_q;
   assign id_wreg       = dec.wreg && !bubble;
   assign id_m2reg      = dec.m2reg && !bubble;
   assign id_wmem       = dec.wmem && !bubble;
   assign id_branch     = dec.branch && !bubble;
   assign id_aluimm     = dec.aluimm;
   assign id_shift      = dec.shift;
   assign id_regrt      = dec.regrt;
   assign id_aluc       = dec.aluc;
   assign id_rt         = rt;
   assign id_rd         = rd;
   assign ID_ins_type   = bubble ? INS_TYPE_NOP : dec.ins_type;
   assign ID_ins_number = num_q;

   always_comb begin
      inst_d = inst_q;
      pc4_d  = pc4_q;
      num_d  = num_q;
      cnt_d  = cnt_q;
      if (id_flush) begin
         inst_d = NOP_WORD;
         pc4_d  = '0;
      end else if (!hazard) begin
         inst_d = if_inst;
         pc4_d  = if_pc4;
         cnt_d  = cnt_q + 4'd1;
         num_d  = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q <= NOP_WORD;
         pc4_q  <= '0;
         num_q  <= '0;
         cnt_q  <= '0;
      end else begin
         inst_q <= inst_d;
         pc4_q  <= pc4_d;
         num_q  <= num_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed plus randomized bench for id_stage against a mnemonic-level model
// of the IF/ID slot, the register contents and the RAW stall rule.
module tb_id_stage;

   typedef enum int {
      M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA,
      M_ADDI, M_ANDI, M_ORI, M_LW, M_SW, M_BEQ, M_BAD_OP, M_BAD_FN
   } mn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] if_inst = '0;
   logic [31:0] if_pc4 = '0;
   logic        id_flush = 1'b0;
   logic        ex_wreg = 1'b0;
   logic [4:0]  ex_destR = '0;
   logic        mem_wreg = 1'b0;
   logic [4:0]  mem_destR = '0;
   logic        wb_wreg = 1'b0;
   logic [4:0]  wb_destR = '0;
   logic [31:0] wb_data = '0;
   logic        id_stall;
   logic [31:0] id_inA, id_inB, id_imm, id_pc4;
   logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_branch, id_regrt;
   logic [3:0]  id_aluc;
   logic [4:0]  id_rt, id_rd;
   logic [3:0]  ID_ins_type, ID_ins_number;

   id_stage dut (
      .clk(clk), .rst_n(rst_n), .if_inst(if_inst), .if_pc4(if_pc4), .id_flush(id_flush),
      .ex_wreg(ex_wreg), .ex_destR(ex_destR), .mem_wreg(mem_wreg), .mem_destR(mem_destR),
      .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_data(wb_data),
      .id_stall(id_stall), .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm), .id_pc4(id_pc4),
      .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluimm(id_aluimm),
      .id_shift(id_shift), .id_branch(id_branch), .id_regrt(id_regrt), .id_aluc(id_aluc),
      .id_rt(id_rt), .id_rd(id_rd), .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;

   // model state
   mn_t         drv_mn = M_NOP;
   mn_t         m_mn;
   logic [31:0] m_inst, m_pc4;
   int          m_num, m_cnt;
   logic [31:0] regs [32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input mn_t m, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm);
      case (m)
         M_ADD:    return {6'h00, rs, rt, rd, sa, 6'h20};
         M_SUB:    return {6'h00, rs, rt, rd, sa, 6'h22};
         M_AND:    return {6'h00, rs, rt, rd, sa, 6'h24};
         M_OR:     return {6'h00, rs, rt, rd, sa, 6'h25};
         M_XOR:    return {6'h00, rs, rt, rd, sa, 6'h26};
         M_SLL:    return {6'h00, rs, rt, rd, sa, 6'h00} | 32'h0000_0800;
         M_SRL:    return {6'h00, rs, rt, rd, sa, 6'h02};
         M_SRA:    return {6'h00, rs, rt, rd, sa, 6'h03};
         M_ADDI:   return {6'h08, rs, rt, imm};
         M_ANDI:   return {6'h0C, rs, rt, imm};
         M_ORI:    return {6'h0D, rs, rt, imm};
         M_LW:     return {6'h23, rs, rt, imm};
         M_SW:     return {6'h2B, rs, rt, imm};
         M_BEQ:    return {6'h04, rs, rt, imm};
         M_BAD_OP: return {6'h3F, rs, rt, imm};
         M_BAD_FN: return {6'h00, rs, rt, rd, sa, 6'h21};
         default:  return 32'h0;
      endcase
   endfunction

   // class: 0 none, 1 R alu, 2 shift, 3 I alu, 4 lw, 5 sw, 6 beq
   function automatic int cls(input mn_t m);
      case (m)
         M_ADD, M_SUB, M_AND, M_OR, M_XOR: return 1;
         M_SLL, M_SRL, M_SRA:              return 2;
         M_ADDI, M_ANDI, M_ORI:            return 3;
         M_LW:                             return 4;
         M_SW:                             return 5;
         M_BEQ:                            return 6;
         default:                          return 0;
      endcase
   endfunction

   function automatic logic [3:0] alu_of(input mn_t m);
      case (m)
         M_SUB, M_BEQ:  return 4'd1;
         M_AND, M_ANDI: return 4'd2;
         M_OR, M_ORI:   return 4'd3;
         M_XOR:         return 4'd4;
         M_SLL:         return 4'd5;
         M_SRL:         return 4'd6;
         M_SRA:         return 4'd7;
         default:       return 4'd0;
      endcase
   endfunction

   function automatic logic [31:0] imm_of(input mn_t m, input logic [31:0] inst);
      logic [15:0] i;
      logic [31:0] sx;
      i  = inst[15:0];
      sx = 32'($signed(i));
      if (cls(m) == 0) return 32'h0;
      if (m == M_ANDI || m == M_ORI) return {16'h0, i};
      if (m == M_BEQ) return sx << 2;
      return sx;
   endfunction

   function automatic logic producer_pending(input logic [4:0] r);
      logic p;
      p = (ex_wreg && ex_destR == r) || (mem_wreg && mem_destR == r);
`ifndef WB_BYPASS_EN
      p = p || (wb_wreg && wb_destR == r);
`endif
      return (r != 0) && p;
   endfunction

   function automatic logic model_hazard();
      int c;
      logic rs_used, rt_used;
      c = cls(m_mn);
      rs_used = (c == 1) || (c >= 3);
      rt_used = (c == 1) || (c == 2) || (c == 5) || (c == 6);
      return (rs_used && producer_pending(m_inst[25:21])) || (rt_used && producer_pending(m_inst[20:16]));
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
      if (wb_wreg && wb_destR == a) return wb_data;
`endif
      return regs[a];
   endfunction

   task automatic model_reset();
      m_mn = M_NOP; m_inst = '0; m_pc4 = '0; m_num = 0; m_cnt = 0;
      for (int i = 0; i < 32; i++) regs[i] = '0;
   endtask

   task automatic check_all();
      int   c;
      logic bub;
      c   = cls(m_mn);
      bub = model_hazard() || id_flush;
      chk("stall", {31'b0, id_stall}, {31'b0, model_hazard() && !id_flush});
      chk("inA", id_inA, model_read(m_inst[25:21]));
      chk("inB", id_inB, model_read(m_inst[20:16]));
      chk("imm", id_imm, imm_of(m_mn, m_inst));
      chk("pc4", id_pc4, m_pc4);
      chk("wreg", {31'b0, id_wreg}, {31'b0, (c >= 1 && c <= 4) && !bub});
      chk("m2reg", {31'b0, id_m2reg}, {31'b0, (c == 4) && !bub});
      chk("wmem", {31'b0, id_wmem}, {31'b0, (c == 5) && !bub});
      chk("branch", {31'b0, id_branch}, {31'b0, (c == 6) && !bub});
      chk("aluimm", {31'b0, id_aluimm}, {31'b0, c >= 3 && c <= 5});
      chk("shift", {31'b0, id_shift}, {31'b0, c == 2});
      chk("regrt", {31'b0, id_regrt}, {31'b0, c >= 3});
      chk("aluc", {28'b0, id_aluc}, {28'b0, alu_of(m_mn)});
      chk("rt", {27'b0, id_rt}, {27'b0, m_inst[20:16]});
      chk("rd", {27'b0, id_rd}, {27'b0, m_inst[15:11]});
      chk("type", {28'b0, ID_ins_type}, bub ? 32'd0 : 32'(c));
      chk("number", {28'b0, ID_ins_number}, 32'(m_num));
   endtask

   task automatic settle();
      #1;
      check_all();
   endtask

   task automatic advance();
      logic        hz;
      logic        do_wr;
      logic [4:0]  wa;
      logic [31:0] wd;
      hz    = model_hazard();
      do_wr = wb_wreg && wb_destR != 0;
      wa    = wb_destR;
      wd    = wb_data;
      @(posedge clk);
      if (id_flush) begin
         m_mn = M_NOP; m_inst = '0; m_pc4 = '0;
      end else if (!hz) begin
         m_cnt = (m_cnt + 1) % 16;
         m_num = m_cnt;
         m_mn = drv_mn; m_inst = if_inst; m_pc4 = if_pc4;
      end
      if (do_wr) regs[wa] = wd;
      @(negedge clk);
   endtask

   task automatic set_inst(input mn_t m, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm);
      drv_mn  = m;
      if_inst = enc(m, rs, rt, rd, 5'd3, imm);
      if_pc4  = if_pc4 + 32'd4;
   endtask

   task automatic clr_side();
      id_flush = 0; ex_wreg = 0; ex_destR = 0; mem_wreg = 0; mem_destR = 0;
      wb_wreg = 0; wb_destR = 0; wb_data = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      settle();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int saved_num;
      int prev_num;
      mn_t pick;
      @(negedge clk);
      clr_side();
      drv_mn = M_NOP; if_inst = '0;
      do_reset();

      // reset and decode of addi $1,$0,5
      set_inst(M_ADDI, 5'd0, 5'd1, 5'd0, 16'd5);
      chk("t1_word", if_inst, 32'h2001_0005);
      settle(); advance();
      set_inst(M_ADD, 5'd1, 5'd2, 5'd3, 16'h0);
      settle();
      chk("t1_imm", id_imm, 32'd5);
      chk("t1_type", {28'b0, ID_ins_type}, 32'd3);
      chk("t1_num", {28'b0, ID_ins_number}, 32'd1);
      chk("t1_regrt", {31'b0, id_regrt}, 32'd1);
      advance();

      // add $3,$1,$2 behind producers at EX then MEM distance
      ex_wreg = 1; ex_destR = 5'd1;
      settle();
      chk("t2_stall_ex", {31'b0, id_stall}, 32'd1);
      chk("t2_bubble_wreg", {31'b0, id_wreg}, 32'd0);
      advance();
      ex_wreg = 0; mem_wreg = 1; mem_destR = 5'd1;
      settle();
      chk("t2_stall_mem", {31'b0, id_stall}, 32'd1);
      advance();
      clr_side();
      set_inst(M_ADD, 5'd4, 5'd0, 5'd6, 16'h0);
      settle();
      chk("t2_issue", {31'b0, id_stall}, 32'd0);
      chk("t2_aluc", {28'b0, id_aluc}, 32'd0);
      chk("t2_type", {28'b0, ID_ins_type}, 32'd1);
      advance();

      // write-back of $4 in the same cycle it is read
      wb_wreg = 1; wb_destR = 5'd4; wb_data = 32'h0000_DEAD;
      set_inst(M_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF);
      settle();
`ifdef WB_BYPASS_EN
      chk("t3_bypass", id_inA, 32'h0000_DEAD);
      chk("t3_nostall", {31'b0, id_stall}, 32'd0);
`else
      chk("t3_wbstall", {31'b0, id_stall}, 32'd1);
`endif
      advance();
      clr_side();
      settle();
      if (cls(m_mn) == 1) begin
         chk("t3_after", id_inA, 32'h0000_DEAD);
         advance();
      end

      // beq, then flush over a stalled dependent add
      set_inst(M_ADD, 5'd1, 5'd2, 5'd7, 16'h0);
      settle();
      chk("t4_imm", id_imm, 32'hFFFF_FFFC);
      chk("t4_branch", {31'b0, id_branch}, 32'd1);
      advance();
      ex_wreg = 1; ex_destR = 5'd1;
      set_inst(M_ADDI, 5'd0, 5'd9, 5'd0, 16'h0009);
      settle();
      chk("t4_stall", {31'b0, id_stall}, 32'd1);
      advance();
      id_flush = 1;
      settle();
      chk("t4_flush_nostall", {31'b0, id_stall}, 32'd0);
      chk("t4_flush_type", {28'b0, ID_ins_type}, 32'd0);
      saved_num = int'(ID_ins_number);
      advance();
      id_flush = 0;
      settle();
      chk("t4_nop_nostall", {31'b0, id_stall}, 32'd0);
      chk("t4_nop_num", {28'b0, ID_ins_number}, 32'(saved_num));
      advance();
      clr_side();
      settle();
      chk("t4_next_num", {28'b0, ID_ins_number}, 32'((saved_num + 1) % 16));

      // r0 is never written and never a hazard
      wb_wreg = 1; wb_destR = 5'd0; wb_data = 32'h0000_1234;
      set_inst(M_ADD, 5'd0, 5'd0, 5'd5, 16'h0);
      advance();
      clr_side();
      ex_wreg = 1; ex_destR = 5'd0; mem_wreg = 1; mem_destR = 5'd0;
      settle();
      chk("t5_r0_stall", {31'b0, id_stall}, 32'd0);
      chk("t5_r0_inA", id_inA, 32'd0);
      chk("t5_r0_inB", id_inB, 32'd0);
      advance();
      clr_side();

      // counter wrap over 17 back-to-back instructions
      prev_num = -1;
      for (int i = 0; i < 17; i++) begin
         set_inst(M_ADDI, 5'd0, 5'(i + 1), 5'd0, 16'(i));
         settle();
         if (prev_num == 15) chk("t6_wrap", {28'b0, ID_ins_number}, 32'd0);
         prev_num = int'(ID_ins_number);
         advance();
      end

      // reset while stalled
      set_inst(M_ADD, 5'd1, 5'd2, 5'd3, 16'h0);
      advance();
      ex_wreg = 1; ex_destR = 5'd2;
      settle();
      chk("t7_pre_stall", {31'b0, id_stall}, 32'd1);
      do_reset();
      clr_side();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         pick = mn_t'($urandom_range(0, 16));
         drv_mn  = pick;
         if_inst = enc(pick, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 16'($urandom));
         if_pc4  = $urandom;
         id_flush  = ($urandom_range(0, 11) == 0);
         ex_wreg   = ($urandom_range(0, 2) == 0);
         ex_destR  = 5'($urandom_range(0, 7));
         mem_wreg  = ($urandom_range(0, 2) == 0);
         mem_destR = 5'($urandom_range(0, 7));
         wb_wreg   = ($urandom_range(0, 1) == 0);
         wb_destR  = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         settle();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage stall-only pipelined CPU. It holds the IF/ID pipeline register, the 32×32 register file, the instruction decoder and the RAW-hazard stall unit. It drives the decoded operands and control word into the execute stage's ID/EXE register, and it sends a stall back to fetch. There is no forwarding in this CPU. Every data hazard is resolved by holding IF/ID and inserting a bubble.

## Interface
- Parameters: none (encodings live in the package).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_inst  in  32  fetched instruction
- if_pc4  in  32  fetched PC+4
- id_flush  in  1  taken branch resolved downstream: squash IF/ID
- ex_wreg, ex_destR  in  1, 5  EX-stage write enable and destination
- mem_wreg, mem_destR  in  1, 5  MEM-stage write enable and destination
- wb_wreg, wb_destR, wb_data  in  1, 5, 32  register-file write port
- id_stall  out  1  hold PC and IF/ID
- id_inA, id_inB  out  32  rs / rt read data
- id_imm  out  32  extended immediate
- id_pc4  out  32  IF/ID PC+4
- id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_branch, id_regrt  out  1 each  control bits
- id_aluc  out  4  ALU op
- id_rt, id_rd  out  5  instruction fields
- ID_ins_type, ID_ins_number  out  4 each  debug tag: class and sequence number

## Operation
- **Supported subset:**
  - R-type: add, sub, and, or, xor, sll, srl, sra.
  - I-type: addi, andi, ori, lw, sw, beq.
  - The all-zero word is a NOP with wreg=0. Any other word outside the subset decodes as a NOP.
- **Immediate (id_imm):**
  - Sign-extended imm16 for addi, lw, sw and shifts. For shifts, sa sits in bits 10:6.
  - Zero-extended for andi and ori.
  - For beq: sign-extended imm16 shifted left by 2.
- **Control bits:**
  - id_regrt=1 for I-type.
  - id_shift=1 for sll/srl/sra.
  - id_aluimm=1 for addi/andi/ori/lw/sw.
  - id_m2reg=1 for lw only; id_wmem=1 for sw only; id_branch=1 for beq only.
  - beq uses ALU_SUB.
- **Operand use for hazards:**
  - rs is used by all ops except shifts and NOP.
  - rt is used by R-type, sw and beq.
- **Stall condition** (id_stall, combinational):
  - A used source register is nonzero and equals ex_destR with ex_wreg=1, or equals mem_destR with mem_wreg=1.
  - While stalled, IF/ID holds its value.
  - All outputs except id_stall, id_pc4 and operands present a bubble: wreg=wmem=branch=m2reg=0, ID_ins_type=0.
- **id_flush:**
  - IF/ID loads NOP on the next edge.
  - Flush overrides stall.
  - The current ID outputs are also forced to a bubble during that cycle.
- **Register file:** write occurs at the rising edge when wb_wreg=1 and wb_destR≠0. Reads are combinational. r0 always reads 0.
- **ID_ins_type:** 0 NOP/bubble, 1 R-type ALU, 2 shift, 3 I-type ALU, 4 lw, 5 sw, 6 beq.
- **ID_ins_number:** a 4-bit counter that increments (wrapping 15→0) at each edge where IF/ID loads a non-flushed instruction. The value is carried in IF/ID alongside the instruction.

## Timing
- **Reset values:** IF/ID=NOP, pc4=0, all registers=0, counter=0. Hence all outputs are 0 and id_stall=0 after reset.
- **Latency:** the decoded result is valid one cycle after if_inst is presented.
- **Stall duration:**
  - A dependent op directly behind its producer stalls 2 cycles; one slot behind, 1 cycle.
  - This holds with the bypass enabled (see Configuration).
- **Reset mid-stall:** clears IF/ID to NOP and deasserts the stall immediately.

## Configuration
- **WB_BYPASS_EN defined:**
  - The register file read returns wb_data when wb_wreg=1 and wb_destR equals the read address (≠0).
  - WB is excluded from the stall check.
- **WB_BYPASS_EN undefined:**
  - Reads see only the pre-edge contents.
  - The stall condition also includes a match with wb_destR/wb_wreg, which adds 1 stall cycle per hazard.

## Structure
- **Package cpu_pkg:**
  - ALU codes: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011, ALU_XOR=4'b0100, ALU_SLL=4'b0101, ALU_SRL=4'b0110, ALU_SRA=4'b0111.
  - Opcode/funct constants.
  - INS_TYPE_* constants.
  - NOP word.
- **Sub-module regfile** (2 read ports, 1 write port, bypass under WB_BYPASS_EN).
- Decoder and stall logic are inline.

## Test plan
1. **Reset and decode:** reset, then `addi $1,$0,5` (0x20010005) → id_imm=5, id_aluimm=1, id_regrt=1, id_rt=1, id_wreg=1, ID_ins_type=3, ID_ins_number=1.
2. **EX-distance hazard:** `add $3,$1,$2` with ex_destR=1, ex_wreg=1 → id_stall=1, bubble outputs. Then with mem_destR=1 → stall persists. Then clear → add issues with id_aluc=ALU_ADD.
3. **Same-cycle bypass:** wb_wreg=1, wb_destR=4, wb_data=0xDEAD while ID reads $4 → id_inA=0xDEAD with the macro defined. Without the macro → id_stall=1.
4. **Branch and flush:**
   - `beq $1,$2,-1` → id_imm=0xFFFFFFFC, id_branch=1.
   - Then id_flush=1 while stalled → next cycle decodes NOP, id_stall=0, counter not incremented.
5. **r0 protection:** wb writes $0=0x1234 → later read of $0 returns 0, and `add $5,$0,$0` never stalls on ex_destR=0.
6. **Counter wrap:** 16 consecutive non-stalled instructions → ID_ins_number goes 15 then 0.
